// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among
// NUM_REQ clients, with a bounded lock/burst hold for tap sweeps.
// Ports: clock, reset (async, active-high); req/lock per client;
//   a_in/b_in packed operands; gnt one-hot Mealy grant;
//   rsp_valid one-hot strobe, rsp_data shared product bus; busy.
// Optional: define MAC_ARB_DEQUANT_EN to shift results right by BITS
//   (rounding toward zero) at the final stage.
module mac_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_SIZE   = 32,
  parameter int PIPE_STAGES = 2,
  parameter int MAX_BURST   = 20,
  parameter int BITS        = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   a_in,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   b_in,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [2*DATA_SIZE-1:0]         rsp_data,
  output logic                           busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int PW = 2 * DATA_SIZE;
  localparam int L  = PIPE_STAGES - 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [NUM_REQ-1:0]     tag_q  [PIPE_STAGES];
  logic [NUM_REQ-1:0]     tag_d  [PIPE_STAGES];
  logic [PW-1:0]          prod_q [PIPE_STAGES];
  logic [PW-1:0]          prod_d [PIPE_STAGES];

  logic [IW-1:0]   base, win, sel, jj;
  logic            found;
  int              j;
  logic [NUM_REQ-1:0] gnt_raw;

  logic signed [DATA_SIZE-1:0] op_a, op_b;
  logic signed [PW-1:0]        ext_a, ext_b, prod;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // When the owner drops req mid-burst, the search starts past it.
  always_comb begin
    base  = (state_q == LOCKED) ? nxt(owner_q) : ptr_q;
    found = 1'b0;
    win   = '0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(base) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_raw = '0;
    sel     = win;
    unique case (state_q)
      ARB: begin
        if (found) begin
          gnt_raw[win] = 1'b1;
          if (lock[win] && MAX_BURST > 1) begin
            state_d = LOCKED;
            owner_d = win;
            cnt_d   = CW'(1);
          end else begin
            ptr_d = nxt(win);
          end
        end
      end
      LOCKED: begin
        if (req[owner_q]) begin
          gnt_raw[owner_q] = 1'b1;
          sel = owner_q;
          if (!lock[owner_q] ||
              cnt_q + CW'(1) >= CW'(MAX_BURST)) begin
            state_d = ARB;
            ptr_d   = nxt(owner_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ARB;
          ptr_d   = nxt(owner_q);
          cnt_d   = '0;
          if (found) begin
            gnt_raw[win] = 1'b1;
            if (lock[win] && MAX_BURST > 1) begin
              state_d = LOCKED;
              owner_d = win;
              cnt_d   = CW'(1);
            end
          end
        end
      end
    endcase
  end

  // No grants are issued while reset is held.
  assign gnt = reset ? '0 : gnt_raw;

  always_comb begin
    op_a  = a_in[int'(sel)*DATA_SIZE +: DATA_SIZE];
    op_b  = b_in[int'(sel)*DATA_SIZE +: DATA_SIZE];
    ext_a = {{DATA_SIZE{op_a[DATA_SIZE-1]}}, op_a};
    ext_b = {{DATA_SIZE{op_b[DATA_SIZE-1]}}, op_b};
    prod  = ext_a * ext_b;
  end

  // Data registers only load on valid so the bus holds its last result.
  always_comb begin
    vld_d[0]  = |gnt;
    tag_d[0]  = gnt;
    prod_d[0] = (|gnt) ? prod : prod_q[0];
    for (int s = 1; s < PIPE_STAGES; s++) begin
      vld_d[s]  = vld_q[s-1];
      tag_d[s]  = tag_q[s-1];
      prod_d[s] = vld_q[s-1] ? prod_q[s-1] : prod_q[s];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        tag_q[s]  <= '0;
        prod_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        tag_q[s]  <= tag_d[s];
        prod_q[s] <= prod_d[s];
      end
    end
  end

  assign rsp_valid = vld_q[L] ? tag_q[L] : '0;
  assign busy      = |vld_q;

`ifdef MAC_ARB_DEQUANT_EN
  logic signed [PW-1:0] p_s, mag;
  always_comb begin
    p_s = prod_q[L];
    mag = '0;
    if (p_s < 0) begin
      mag      = (-p_s) >>> BITS;
      rsp_data = -mag;
    end else begin
      rsp_data = p_s >>> BITS;
    end
  end
`else
  assign rsp_data = prod_q[L];
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter with a response scoreboard.
// Grants are checked in-cycle; products are checked 2 cycles later.
module tb_mac_share_arbiter;

  logic         clock;
  logic         reset;
  logic [3:0]   req, lock;
  logic [127:0] a_in, b_in;
  logic [3:0]   gnt, rsp_valid;
  logic [63:0]  rsp_data;
  logic         busy;

  logic signed [31:0] ta [4];
  logic signed [31:0] tb [4];

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  assign a_in = {ta[3], ta[2], ta[1], ta[0]};
  assign b_in = {tb[3], tb[2], tb[1], tb[0]};

  mac_share_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .lock(lock),
    .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] model(input int idx);
    longint p;
    p = longint'(ta[idx]) * longint'(tb[idx]);
`ifdef MAC_ARB_DEQUANT_EN
    if (p < 0) p = -((-p) >>> 10);
    else p = p >>> 10;
`endif
    return p;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d: observed %h expected %h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] eg, input bit cg);
    exp_t e;
    bit   busy_exp;
    int   idx;
    @(negedge clock);
    busy_exp = (sb.size() > 0);
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("rsp_tag", 64'(rsp_valid), 64'(e.tag));
      check("rsp_data", rsp_data, e.data);
      check("rsp_due", 64'(cyc), 64'(e.due));
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'd0);
    end
    check("busy", 64'(busy), 64'(busy_exp));
    if (cg) check("gnt", 64'(gnt), 64'(eg));
    if (gnt != 4'd0) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
      e.tag  = gnt;
      e.data = model(idx);
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain();
    req  = 4'd0;
    lock = 4'd0;
    for (int n = 0; n < 8 && sb.size() > 0; n++) step(4'd0, 1'b1);
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    cyc++;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom;
    end
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'd0;
    lock  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      ta[i] = 32'sd0;
      tb[i] = 32'sd0;
    end
    #1;
    do_reset();

    // Single client, 3 * -7 = -21.
    ta[0] = 32'sd3;
    tb[0] = -32'sd7;
    req   = 4'b0001;
    step(4'b0001, 1'b1);
    req = 4'd0;
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    check("single_sum", 64'(sb.size()), 64'd0);
    step(4'd0, 1'b1);

    // Plain round-robin among all four clients.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step(4'b0001 << (k % 4), 1'b1);
    end
    drain();

    // Reset with two operations in flight.
    do_reset();
    req = 4'b1111;
    rand_ops();
    step(4'b0001, 1'b1);
    rand_ops();
    step(4'b0010, 1'b1);
    do_reset();
    req = 4'b1111;
    rand_ops();
    step(4'b0001, 1'b1);
    drain();

    // Burst bounded at 20 grants, then fair rotation.
    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    rand_ops();
    step(4'b0100, 1'b1);
    req = 4'b1101;
    for (int k = 0; k < 19; k++) begin
      rand_ops();
      step(4'b0100, 1'b1);
    end
    step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    drain();

    // Owner drops req mid-burst; other client wins that cycle.
    do_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    rand_ops();
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    req  = 4'b0001;
    lock = 4'b0000;
    step(4'b0001, 1'b1);
    req = 4'b0111;
    step(4'b0100, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    drain();

    // Dequant operands (raw product when the feature is off).
    do_reset();
    ta[3] = 32'sh00000257;
    tb[3] = -32'sd5000;
    req   = 4'b1000;
    step(4'b1000, 1'b1);
    tb[3] = 32'sd5000;
    step(4'b1000, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_share_arbiter.md
# mac_share_arbiter

Round-robin arbiter that shares one pipelined signed multiplier among several FIR clients. Typical clients are the complex channel FIR, the demod FIRs and the audio left/right FIRs. Each client issues one operand pair per granted cycle and gets the product back tagged to it a fixed number of cycles later. A lock/burst mechanism lets one client stream a full tap sweep without re-arbitration, bounded so the other clients are not starved.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting clients (2..8)
- DATA_SIZE, 32, operand width in bits (signed)
- PIPE_STAGES, 2, multiplier pipeline depth (≥1); this is the grant-to-response latency
- MAX_BURST, 20, maximum consecutive locked grants to one client
- BITS, 10, dequantization shift (used only with MAC_ARB_DEQUANT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-client request; operands on a_in/b_in are valid while high
- lock  in  NUM_REQ  per-client burst-hold request, qualified by req
- a_in  in  NUM_REQ*DATA_SIZE  client i operand A at slice [i*DATA_SIZE +: DATA_SIZE]
- b_in  in  NUM_REQ*DATA_SIZE  client i operand B, same packing as a_in
- gnt  out  NUM_REQ  one-hot grant; operands are consumed at the clock edge where req[i]&gnt[i]
- rsp_valid  out  NUM_REQ  one-hot response strobe to the issuing client
- rsp_data  out  2*DATA_SIZE  shared result bus, valid when any rsp_valid bit is high
- busy  out  1  high while any issued operation is still in the pipeline

## Operation
- Reset values:
  - gnt=0, rsp_valid=0, rsp_data=0, busy=0.
  - Priority pointer ptr=0. State IDLE, burst counter 0, pipeline valid/tag bits cleared.
- IDLE/ARB state:
  - gnt goes to the first requesting client at or after ptr, modulo NUM_REQ.
  - After a grant to client i: if req[i]&lock[i], go to LOCKED with owner=i and burst count 1. Otherwise ptr=(i+1)%NUM_REQ and stay in ARB.
- LOCKED state:
  - gnt is held on the owner while req[owner]&lock[owner]; the burst count increments each granted cycle.
  - Exit to ARB with ptr=(owner+1)%NUM_REQ when any of these holds:
    - lock[owner] drops: this cycle is still granted if req is high; it is the final grant.
    - req[owner] drops: no grant this cycle; the cycle is re-arbitrated among the other clients.
    - The burst count reaches MAX_BURST: that grant is the last one; the owner competes normally afterwards.
- With no requests, gnt=0 and ptr is unchanged.
- Arithmetic: the full-precision signed product a*b is 2*DATA_SIZE bits, with no truncation in the pipeline.
- The pipeline carries {valid, one-hot tag, product} through PIPE_STAGES registers.
- No backpressure: clients must accept a response in the cycle it is presented.
- busy = OR of all pipeline valid bits.

## Timing
- gnt is combinational (Mealy) from req, lock, state and ptr in the same cycle; there is no registered grant delay.
- Throughput is one operation per cycle. A grant issued in cycle k produces rsp_valid and rsp_data in cycle k+PIPE_STAGES.
- Back-to-back grants to different clients give back-to-back responses in grant order. The result bus is never shared within a cycle.
- rsp_data holds its last value when no rsp_valid bit is high.
- Reset mid-operation: all in-flight operations are dropped, and no rsp_valid is asserted after reset is released until new grants mature.
- Simultaneous lock release and request from another client: the other client can win in the next cycle, not the same cycle.
- MAX_BURST=1 degenerates locking to plain round-robin.

## Configuration
- MAC_ARB_DEQUANT_EN defined:
  - Final stage output is DEQUANTIZE(p), sign-extended to 2*DATA_SIZE.
  - For p<0: -((-p)>>>BITS). Otherwise: p>>>BITS. Rounding is toward zero.
  - Latency is unchanged.
- Not defined: rsp_data is the raw product p.

## Test plan
- Single client: req[0]=1 with a=3, b=-7, no lock. Expect gnt[0] in the same cycle, rsp_valid[0]=1 with rsp_data=-21 exactly 2 cycles later (raw build), and busy high for those 2 cycles.
- All four clients requesting continuously with no lock, starting from reset. Expect grant order 0,1,2,3,0,... one per cycle, and response tags in the same order 2 cycles later.
- Client 2 asserts req and lock for 25 cycles while clients 0 and 3 also request. Expect exactly 20 consecutive gnt[2], then gnt[3], then gnt[0], then client 2 again.
- Reset pulse while 2 operations are in flight. Expect no rsp_valid during or after reset, all outputs 0, and the next grant going to client 0.
- Dequant build with a=0x00000257, b=-5000. The product is -2995000, so expect rsp_data=-2924 (toward zero). With b=+5000, expect +2924.
- Client 1 locked and dropping req mid-burst while client 0 requests. Expect gnt[0] in that same cycle, ptr advanced to 2, and no further gnt[1] until it wins arbitration.
